// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART blocks (uart_rx, uart_baud_cnt and
// the future uart_tx).
//   rx_state_t       : receiver FSM state encoding
//   CLKS_PER_BIT_DEF : default bit period in clk cycles (100 MHz / 115200)
//   DATA_BITS_DEF    : default data bits per frame
//   xor_reduce9()    : XOR of a word of up to 9 bits (zero-extend narrower
//                      words); used for even-parity checking
// Optional feature macro: UART_RX_PARITY_EN (the PARITY state is only reached
// when it is defined).
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 868;
  localparam int unsigned DATA_BITS_DEF    = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  function automatic logic xor_reduce9(input logic [8:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// ---------------------------------------------------------------------------
// uart_baud_cnt
// Bit-period cycle counter. Counts 0..CLKS_PER_BIT-1 and wraps, or is forced
// to 0 by clr_i. The tick outputs are decoded from the current count, so a
// consumer that clears on state entry sees its first tick CLKS_PER_BIT/2 or
// CLKS_PER_BIT cycles after that entry.
// Ports:
//   clk_i       : clock
//   nrst_i      : synchronous active-low reset
//   clr_i       : force count to 0 at the next edge
//   half_tick_o : count == CLKS_PER_BIT/2-1 (mid-bit of the start bit)
//   full_tick_o : count == CLKS_PER_BIT-1   (end of a full bit period)
// ---------------------------------------------------------------------------
module uart_baud_cnt #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic clk_i,
  input  logic nrst_i,
  input  logic clr_i,
  output logic half_tick_o,
  output logic full_tick_o
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] cnt_q, cnt_d;

  assign half_tick_o = (cnt_q == CW'(CLKS_PER_BIT / 2 - 1));
  assign full_tick_o = (cnt_q == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || full_tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// UART receive deserializer fed by the 2-flop synchronizer output. Finds the
// start bit, samples each bit in its middle, shifts data in LSB first, checks
// the stop bit and hands each word over a valid/ready interface.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | line idle, waiting for a low level
// START     | half a bit period, then confirm start bit still low
// DATA      | one full bit period per data bit, sample at the end
// PARITY    | one bit period for the parity bit (UART_RX_PARITY_EN only)
// STOP      | one bit period, stop bit must be high
// WAIT_HIGH | bad stop bit / break: wait for the line to return high
//
// Ports:
//   clk        : clock
//   nrst       : synchronous active-low reset; abandons any frame in flight
//   rx_sync    : synchronized serial line, idle high
//   rx_data    : received word, stable while rx_valid=1
//   rx_valid   : word available, held until accepted
//   rx_ready   : consumer accepts when rx_valid & rx_ready
//   frame_err  : one-cycle pulse, stop bit sampled low (word discarded)
//   parity_err : one-cycle pulse with the word's completion when even parity
//                fails; word is still delivered (UART_RX_PARITY_EN only)
//   overrun    : one-cycle pulse, completed word dropped because the
//                previous one was still waiting
// Optional feature macro: UART_RX_PARITY_EN
// ---------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned DATA_BITS    = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 rx_sync,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 overrun
);

  localparam int unsigned IW = $clog2(DATA_BITS + 1);

  rx_state_t state_q, state_d;

  logic                 half_tick, full_tick, cnt_clr;
  logic                 start_ok, shift_en, word_done, stop_bad;
  logic [IW-1:0]        bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q, frame_err_q, overrun_q;
  logic                 load_word;
`ifdef UART_RX_PARITY_EN
  logic                 par_sample;
  logic                 parity_bit_q, parity_err_q;
`endif

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk_i      (clk),
    .nrst_i     (nrst),
    .clr_i      (cnt_clr),
    .half_tick_o(half_tick),
    .full_tick_o(full_tick)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!rx_sync) state_d = START;
      end
      START: begin
        if (half_tick) state_d = rx_sync ? IDLE : DATA;
      end
      DATA: begin
        if (full_tick && (bit_idx_q == IW'(DATA_BITS - 1))) begin
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (full_tick) state_d = STOP;
      end
`endif
      STOP: begin
        if (full_tick) state_d = rx_sync ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (rx_sync) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-state control strobes
  always_comb begin
    start_ok  = 1'b0;
    shift_en  = 1'b0;
    word_done = 1'b0;
    stop_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_sample = 1'b0;
`endif
    case (state_q)
      START: start_ok = half_tick && !rx_sync;
      DATA:  shift_en = full_tick;
`ifdef UART_RX_PARITY_EN
      PARITY: par_sample = full_tick;
`endif
      STOP: begin
        word_done = full_tick && rx_sync;
        stop_bad  = full_tick && !rx_sync;
      end
      default: ;
    endcase
    // Counter restarts on every state change so each state times from 0;
    // it is also held at 0 while the line is not being timed.
    cnt_clr = (state_d != state_q) || (state_q == IDLE) || (state_q == WAIT_HIGH);
  end

  // A finished word loads if the holding register is empty or being
  // emptied in this same cycle; otherwise it is dropped as an overrun.
  assign load_word = word_done && (!rx_valid_q || rx_ready);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (start_ok) begin
        bit_idx_q <= '0;
      end else if (shift_en) begin
        bit_idx_q <= bit_idx_q + 1'b1;
      end

      if (shift_en) begin
        shift_q <= {rx_sync, shift_q[DATA_BITS-1:1]};
      end

      frame_err_q <= stop_bad;
      overrun_q   <= word_done && rx_valid_q && !rx_ready;

      if (load_word) begin
        rx_data_q  <= shift_q;
        rx_valid_q <= 1'b1;
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!nrst) begin
      parity_bit_q <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      if (par_sample) parity_bit_q <= rx_sync;
      parity_err_q <= word_done && (xor_reduce9(9'(shift_q)) ^ parity_bit_q);
    end
  end

  assign parity_err = parity_err_q;
`endif

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Scoreboard bench for uart_rx with CLKS_PER_BIT=4, DATA_BITS=8. Expected
// words are queued as frames are sent and popped on each valid/ready
// handshake; flag pulses are counted by the monitor and checked per scenario.
// Honours UART_RX_PARITY_EN when defined.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int C = 4;
  localparam int D = 8;
`ifdef UART_RX_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif
  // Edges from the cycle the start bit is driven to the edge that registers
  // rx_valid: one edge for IDLE to see the low level, half a bit for START,
  // then data (+parity) + stop full bits.
  localparam int DONE_OFS = 1 + C / 2 + (D + NPAR + 1) * C;

  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic         rx_sync = 1'b1;
  logic         rx_ready = 1'b0;
  logic [D-1:0] rx_data;
  logic         rx_valid, frame_err, overrun;
`ifdef UART_RX_PARITY_EN
  logic         parity_err;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = -1;
  int words = 0;
  int valid_hi_cnt = 0;
  int frame_err_cnt = 0;
  int overrun_cnt = 0;
  int parity_err_cnt = 0;
  int parity_err_cyc = -1;
  logic valid_prev = 1'b0;
  logic [D-1:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(
    .CLKS_PER_BIT(C),
    .DATA_BITS   (D)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .rx_sync   (rx_sync),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .overrun   (overrun)
  );

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame; the line is left at the stop-bit level afterwards.
  task automatic send_frame(input logic [D-1:0] data, input logic stop_val,
                            input logic par_flip);
    start_cyc = cyc;
    rx_sync = 1'b0;
    wait_cyc(C);
    for (int i = 0; i < D; i++) begin
      rx_sync = data[i];
      wait_cyc(C);
    end
`ifdef UART_RX_PARITY_EN
    rx_sync = (^data) ^ par_flip;
    wait_cyc(C);
`endif
    rx_sync = stop_val;
    wait_cyc(C);
  endtask

  task automatic run_monitor();
    logic [D-1:0] exp;
    forever begin
      @(negedge clk);
      if (rx_valid && !valid_prev) rise_cyc = cyc;
      valid_prev = rx_valid;
      if (rx_valid)  valid_hi_cnt++;
      if (frame_err) frame_err_cnt++;
      if (overrun)   overrun_cnt++;
`ifdef UART_RX_PARITY_EN
      if (parity_err) begin
        parity_err_cnt++;
        parity_err_cyc = cyc;
      end
`endif
      if (rx_valid && rx_ready) begin
        words++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL scoreboard_extra: got word 0x%0h, expected none", rx_data);
        end else begin
          exp = exp_q.pop_front();
          if (rx_data !== exp) begin
            miscompares++;
            $display("FAIL scoreboard_data: got 0x%0h, expected 0x%0h", rx_data, exp);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    rx_sync = 1'b1;
    rx_ready = 1'b0;
    wait_cyc(3);
    vectors++;
    if (rx_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_valid: got %b, expected 0", rx_valid);
    end
    vectors++;
    if (rx_data !== '0) begin
      miscompares++; $display("FAIL reset_data: got 0x%0h, expected 0", rx_data);
    end
    vectors++;
    if (frame_err !== 1'b0) begin
      miscompares++; $display("FAIL reset_frame_err: got %b, expected 0", frame_err);
    end
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++; $display("FAIL reset_overrun: got %b, expected 0", overrun);
    end
    nrst = 1'b1;
    wait_cyc(2);
  endtask

  task automatic test_single();
    int w0, v0, f0, o0;
    rx_ready = 1'b1;
    w0 = words; v0 = valid_hi_cnt; f0 = frame_err_cnt; o0 = overrun_cnt;
    rise_cyc = -1;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    wait_cyc(4);
    vectors++;
    if (words != w0 + 1) begin
      miscompares++; $display("FAIL single_words: got %0d, expected %0d", words - w0, 1);
    end
    vectors++;
    if (rise_cyc - start_cyc != DONE_OFS) begin
      miscompares++;
      $display("FAIL single_latency: got %0d, expected %0d", rise_cyc - start_cyc, DONE_OFS);
    end
    vectors++;
    if (valid_hi_cnt - v0 != 1) begin
      miscompares++;
      $display("FAIL single_valid_cycles: got %0d, expected 1", valid_hi_cnt - v0);
    end
    vectors++;
    if ((frame_err_cnt != f0) || (overrun_cnt != o0)) begin
      miscompares++;
      $display("FAIL single_flags: got fe=%0d ov=%0d, expected 0 0",
               frame_err_cnt - f0, overrun_cnt - o0);
    end
  endtask

  task automatic test_glitch();
    int w0, f0;
    rx_ready = 1'b1;
    w0 = words; f0 = frame_err_cnt;
    rx_sync = 1'b0;
    wait_cyc(2);
    rx_sync = 1'b1;
    wait_cyc(3 * C);
    vectors++;
    if ((words != w0) || (rx_valid !== 1'b0)) begin
      miscompares++;
      $display("FAIL glitch_no_word: got words=%0d valid=%b, expected 0 0", words - w0, rx_valid);
    end
    vectors++;
    if (frame_err_cnt != f0) begin
      miscompares++; $display("FAIL glitch_frame_err: got %0d, expected 0", frame_err_cnt - f0);
    end
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b0);
    wait_cyc(4);
    vectors++;
    if (words != w0 + 1) begin
      miscompares++; $display("FAIL glitch_next_frame: got %0d words, expected 1", words - w0);
    end
  endtask

  task automatic test_framing();
    int w0, v0, f0;
    rx_ready = 1'b1;
    w0 = words; v0 = valid_hi_cnt; f0 = frame_err_cnt;
    send_frame(8'h55, 1'b0, 1'b0);
    wait_cyc(3 * C);
    vectors++;
    if (frame_err_cnt != f0 + 1) begin
      miscompares++; $display("FAIL framing_pulse: got %0d cycles, expected 1", frame_err_cnt - f0);
    end
    vectors++;
    if ((valid_hi_cnt != v0) || (words != w0)) begin
      miscompares++;
      $display("FAIL framing_no_word: got valid_cycles=%0d, expected 0", valid_hi_cnt - v0);
    end
    rx_sync = 1'b1;
    wait_cyc(2);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 1'b0);
    wait_cyc(4);
    vectors++;
    if ((words != w0 + 1) || (frame_err_cnt != f0 + 1)) begin
      miscompares++;
      $display("FAIL framing_recover: got words=%0d fe=%0d, expected 1 1",
               words - w0, frame_err_cnt - f0);
    end
  endtask

  task automatic test_overrun();
    int w0, o0;
    rx_ready = 1'b0;
    w0 = words; o0 = overrun_cnt;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    wait_cyc(4);
    vectors++;
    if (overrun_cnt != o0 + 1) begin
      miscompares++; $display("FAIL overrun_pulse: got %0d cycles, expected 1", overrun_cnt - o0);
    end
    vectors++;
    if ((rx_valid !== 1'b1) || (rx_data !== 8'h11)) begin
      miscompares++;
      $display("FAIL overrun_hold: got valid=%b data=0x%0h, expected 1 0x11", rx_valid, rx_data);
    end
    rx_ready = 1'b1;
    wait_cyc(1);
    vectors++;
    if (rx_valid !== 1'b0) begin
      miscompares++; $display("FAIL overrun_release: got valid=%b, expected 0", rx_valid);
    end
    vectors++;
    if (words != w0 + 1) begin
      miscompares++; $display("FAIL overrun_words: got %0d, expected 1", words - w0);
    end
  endtask

  task automatic test_back_to_back();
    int w0, o0;
    rx_ready = 1'b0;
    w0 = words; o0 = overrun_cnt;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b0);
    wait_cyc(2);
    exp_q.push_back(8'h22);
    fork
      send_frame(8'h22, 1'b1, 1'b0);
      begin
        wait_cyc(DONE_OFS - 1);
        rx_ready = 1'b1;
        wait_cyc(1);
        rx_ready = 1'b0;
      end
    join
    wait_cyc(2);
    vectors++;
    if (overrun_cnt != o0) begin
      miscompares++; $display("FAIL b2b_overrun: got %0d cycles, expected 0", overrun_cnt - o0);
    end
    vectors++;
    if ((rx_valid !== 1'b1) || (rx_data !== 8'h22)) begin
      miscompares++;
      $display("FAIL b2b_new_word: got valid=%b data=0x%0h, expected 1 0x22", rx_valid, rx_data);
    end
    rx_ready = 1'b1;
    wait_cyc(2);
    vectors++;
    if ((words != w0 + 2) || (rx_valid !== 1'b0)) begin
      miscompares++;
      $display("FAIL b2b_drain: got words=%0d valid=%b, expected 2 0", words - w0, rx_valid);
    end
  endtask

  task automatic test_reset_mid();
    int w0, f0, o0;
    rx_ready = 1'b1;
    w0 = words; f0 = frame_err_cnt; o0 = overrun_cnt;
    fork
      send_frame(8'hF8, 1'b1, 1'b0);
      begin
        wait_cyc(21);
        nrst = 1'b0;
        wait_cyc(1);
        nrst = 1'b1;
        vectors++;
        if ({rx_valid, frame_err, overrun} !== 3'b000) begin
          miscompares++;
          $display("FAIL midreset_flags: got v/fe/ov=%b%b%b, expected 000", rx_valid, frame_err, overrun);
        end
        vectors++;
        if (rx_data !== '0) begin
          miscompares++; $display("FAIL midreset_data: got 0x%0h, expected 0", rx_data);
        end
      end
    join
    wait_cyc(C);
    exp_q.push_back(8'hF0);
    send_frame(8'hF0, 1'b1, 1'b0);
    wait_cyc(4);
    vectors++;
    if ((words != w0 + 1) || (frame_err_cnt != f0) || (overrun_cnt != o0)) begin
      miscompares++;
      $display("FAIL midreset_next: got words=%0d fe=%0d ov=%0d, expected 1 0 0",
               words - w0, frame_err_cnt - f0, overrun_cnt - o0);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int w0, p0;
    rx_ready = 1'b1;
    w0 = words; p0 = parity_err_cnt;
    vectors++;
    if (p0 != 0) begin
      miscompares++; $display("FAIL parity_clean: got %0d pulses on good frames, expected 0", p0);
    end
    rise_cyc = -1;
    exp_q.push_back(8'hF0);
    send_frame(8'hF0, 1'b1, 1'b1);
    wait_cyc(4);
    vectors++;
    if (parity_err_cnt != p0 + 1) begin
      miscompares++; $display("FAIL parity_pulse: got %0d cycles, expected 1", parity_err_cnt - p0);
    end
    vectors++;
    if ((parity_err_cyc != rise_cyc) || (rise_cyc < 0)) begin
      miscompares++;
      $display("FAIL parity_align: got cycle %0d, expected %0d", parity_err_cyc, rise_cyc);
    end
    vectors++;
    if (words != w0 + 1) begin
      miscompares++; $display("FAIL parity_delivered: got %0d words, expected 1", words - w0);
    end
  endtask
`endif

  initial begin
    fork
      run_monitor();
    join_none
    test_reset();
    test_single();
    test_glitch();
    test_framing();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    wait_cyc(2);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL scoreboard_left: got %0d words pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
